// File: rtl/clock_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : clock_pkg
//  Description : Shared constants for the digital clock set-mode logic:
//                one-hot time-adjust FSM encodings and default hold/repeat
//                timing in tick_ms periods.
//  Revision    : 1.0 - initial release
// ============================================================================
package clock_pkg;

    // One-hot encodings of the time-adjust sequencer states
    localparam logic [3:0] c_st_idle    = 4'b0001;
    localparam logic [3:0] c_st_hold    = 4'b0010;
    localparam logic [3:0] c_st_repeat  = 4'b0100;
    localparam logic [3:0] c_st_lockout = 4'b1000;

    // Default press-and-hold timing, in tick_ms periods
    localparam int c_hold_ms_dflt   = 500;
    localparam int c_repeat_ms_dflt = 150;
    localparam int c_cnt_w_dflt     = 10;

endpackage : clock_pkg
`default_nettype wire

// File: rtl/btn_sync.sv
`default_nettype none
// ============================================================================
//  Module      : btn_sync
//  Description : Two-flop synchronizer for an active-low button. Resets to
//                the released level (1) so a reset never looks like a press.
//  Revision    : 1.0 - initial release
// ============================================================================
module btn_sync (
    input  logic clk,
    input  logic rst,     // asynchronous, active-low
    input  logic d,
    output logic q
);

    logic r_meta;
    logic r_sync;

    // Two-stage resynchronisation into the clk domain
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_meta <= 1'b1;
            r_sync <= 1'b1;
        end else begin
            r_meta <= d;
            r_sync <= r_meta;
        end
    end

    assign q = r_sync;

endmodule : btn_sync
`default_nettype wire

// File: rtl/time_adjust_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : time_adjust_sequencer
//  Description : Set-mode increment sequencer. Turns a held active-low button
//                into hour/minute increment pulses with press-and-hold
//                auto-repeat, freezes the seconds tick during set mode and
//                clears seconds when set mode ends.
//  Revision    : 1.0 - initial release
// ============================================================================
module time_adjust_sequencer
    import clock_pkg::*;
#(
    parameter int HOLD_MS   = c_hold_ms_dflt,
    parameter int REPEAT_MS = c_repeat_ms_dflt,
    parameter int CNT_W     = c_cnt_w_dflt
) (
    input  logic clk,
    input  logic rst,        // asynchronous, active-low
    input  logic tick_ms,
    input  logic sec_tick,
    input  logic setting,
    input  logic setting_h,
    input  logic setting_m,
    input  logic btn_inc,
    output logic inc_hr,
    output logic inc_min,
    output logic sec_en,
    output logic sec_clr,
    output logic repeating
);

    logic [3:0]       r_state;
    logic [CNT_W-1:0] r_cnt;
    logic             r_tgt_hr;     // field captured at press: 1 = hours
    logic             r_inc_hr;
    logic             r_inc_min;
    logic             r_setting_d;
    logic             r_sec_en;
    logic             r_sec_clr;

    logic             w_btn_sync;
    logic             w_pressed;
    logic             w_valid;
    logic             w_changed;
    logic             w_term;
    logic             w_sec_fall;

    btn_sync u_btn_sync (
        .clk (clk),
        .rst (rst),
        .d   (btn_inc),
        .q   (w_btn_sync)
    );

    assign w_pressed = ~w_btn_sync;

    // Exactly one field selected while in set mode
    assign w_valid   = setting & (setting_h ^ setting_m);

    // Any departure from the field captured at press time
    assign w_changed = ~w_valid | (setting_h != r_tgt_hr);

    // Terminal count for the current timing phase
    assign w_term    = (r_state == c_st_hold) ? (r_cnt == CNT_W'(HOLD_MS - 1))
                                              : (r_cnt == CNT_W'(REPEAT_MS - 1));

    // Press/hold/repeat FSM with its tick counter and increment pulses
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state   <= c_st_idle;
            r_cnt     <= '0;
            r_tgt_hr  <= 1'b0;
            r_inc_hr  <= 1'b0;
            r_inc_min <= 1'b0;
        end else begin
            r_inc_hr  <= 1'b0;
            r_inc_min <= 1'b0;
            case (r_state)
                c_st_idle: begin
                    if (w_pressed && w_valid) begin
                        r_state   <= c_st_hold;
                        r_cnt     <= '0;
                        r_tgt_hr  <= setting_h;
                        r_inc_hr  <= setting_h;
                        r_inc_min <= setting_m;
                    end
                end
                c_st_hold, c_st_repeat: begin
                    // Release beats any coincident tick or terminal count
                    if (!w_pressed) begin
                        r_state <= c_st_idle;
                        r_cnt   <= '0;
                    end else if (w_changed) begin
                        r_state <= c_st_lockout;
                        r_cnt   <= '0;
                    end else if (tick_ms) begin
                        if (w_term) begin
                            r_state   <= c_st_repeat;
                            r_cnt     <= '0;
                            r_inc_hr  <= r_tgt_hr;
                            r_inc_min <= ~r_tgt_hr;
                        end else begin
                            r_cnt <= r_cnt + CNT_W'(1);
                        end
                    end
                end
                c_st_lockout: begin
                    // Wait for release so a held button never moves fields
                    if (!w_pressed) begin
                        r_state <= c_st_idle;
                        r_cnt   <= '0;
                    end
                end
                default: begin
                    r_state <= c_st_idle;
                    r_cnt   <= '0;
                end
            endcase
        end
    end

    assign w_sec_fall = r_setting_d & ~setting;

    // Seconds gating during set mode and clear on set-mode exit (clear wins)
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_setting_d <= 1'b0;
            r_sec_en    <= 1'b0;
            r_sec_clr   <= 1'b0;
        end else begin
            r_setting_d <= setting;
            r_sec_clr   <= w_sec_fall;
            r_sec_en    <= sec_tick & ~setting & ~w_sec_fall;
        end
    end

    assign inc_hr    = r_inc_hr;
    assign inc_min   = r_inc_min;
    assign sec_en    = r_sec_en;
    assign sec_clr   = r_sec_clr;
    assign repeating = (r_state == c_st_repeat);

endmodule : time_adjust_sequencer
`default_nettype wire
